// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: per-register pending-write counters gate instruction issue.
// Optional SCOREBOARD_WB_BYPASS_EN lets a same-cycle retirement release a dependent source.
module scoreCell #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             inc,
  input  logic             wbHit,
  output logic [CNT_W-1:0] cnt,
  output logic             busy
);
  logic [CNT_W-1:0] cntNext;
  logic             dec;

  // A retirement on an empty counter is an underflow, handled by the top; never wrap.
  assign dec = wbHit && (cnt != '0);

  always_comb begin
    cntNext = cnt;
    if (flush) cntNext = '0;
    else       cntNext = cnt + CNT_W'(inc) - CNT_W'(dec);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      cnt  <= cntNext;
      busy <= (cntNext != '0);
    end
  end
endmodule

module reg_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int CNT_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic                issue_use_src1,
  input  logic [ADDR_W-1:0]   issue_src1,
  input  logic                issue_use_src2,
  input  logic [ADDR_W-1:0]   issue_src2,
  input  logic                issue_has_dst,
  input  logic [ADDR_W-1:0]   issue_dst,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [15:0]         stall_count,
  output logic                wb_underflow
);
  typedef struct packed {
    logic              valid;
    logic              useSrc1;
    logic [ADDR_W-1:0] src1;
    logic              useSrc2;
    logic [ADDR_W-1:0] src2;
    logic              hasDst;
    logic [ADDR_W-1:0] dst;
  } issueReq_t;

  issueReq_t                       req;
  logic [NUM_REGS-1:0][CNT_W-1:0]  cnt;
  logic [NUM_REGS-1:0]             incVec;
  logic [NUM_REGS-1:0]             wbVec;
  logic [CNT_W-1:0]                eff1, eff2;
  logic                            hz1, hz2, dfull, fire, retire, stalled;

  assign req = '{valid: issue_valid, useSrc1: issue_use_src1, src1: issue_src1,
                 useSrc2: issue_use_src2, src2: issue_src2,
                 hasDst: issue_has_dst, dst: issue_dst};

  assign retire = wb_valid && !flush;

`ifdef SCOREBOARD_WB_BYPASS_EN
  // Last pending write retiring now counts as already done; execute takes the wb data.
  assign eff1 = cnt[req.src1] - CNT_W'(retire && (wb_addr == req.src1) && (cnt[req.src1] != '0));
  assign eff2 = cnt[req.src2] - CNT_W'(retire && (wb_addr == req.src2) && (cnt[req.src2] != '0));
`else
  assign eff1 = cnt[req.src1];
  assign eff2 = cnt[req.src2];
`endif

  assign hz1         = req.useSrc1 && (eff1 != '0);
  assign hz2         = req.useSrc2 && (eff2 != '0);
  assign dfull       = req.hasDst && (cnt[req.dst] == {CNT_W{1'b1}});
  assign issue_ready = !rst && !flush && !hz1 && !hz2 && !dfull;
  assign fire        = req.valid && issue_ready;
  assign stalled     = req.valid && !issue_ready && !flush;

  for (genvar i = 0; i < NUM_REGS; i++) begin : gReg
    assign incVec[i] = fire && req.hasDst && (req.dst == ADDR_W'(i));
    assign wbVec[i]  = retire && (wb_addr == ADDR_W'(i));

    scoreCell #(.CNT_W(CNT_W)) uCell (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .inc   (incVec[i]),
      .wbHit (wbVec[i]),
      .cnt   (cnt[i]),
      .busy  (busy_mask[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count  <= '0;
      wb_underflow <= 1'b0;
    end else begin
      if (stalled && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
      if (retire && (cnt[wb_addr] == '0)) wb_underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard; expectations follow the bypass macro when defined.
module tb_reg_scoreboard;
  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready;
  logic        issue_use_src1, issue_use_src2, issue_has_dst;
  logic [3:0]  issue_src1, issue_src2, issue_dst;
  logic        wb_valid, flush;
  logic [3:0]  wb_addr;
  logic [15:0] busy_mask, stall_count;
  logic        wb_underflow;

  int total = 0;
  int bad   = 0;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  logic [15:0] stExp;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_use_src1(issue_use_src1), .issue_src1(issue_src1),
    .issue_use_src2(issue_use_src2), .issue_src2(issue_src2),
    .issue_has_dst(issue_has_dst), .issue_dst(issue_dst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
    .busy_mask(busy_mask), .stall_count(stall_count), .wb_underflow(wb_underflow)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 0; issue_use_src1 = 0; issue_use_src2 = 0; issue_has_dst = 0;
    issue_src1 = 0; issue_src2 = 0; issue_dst = 0; wb_valid = 0; wb_addr = 0; flush = 0;
  endtask

  // Advance one rising edge, then let outputs settle away from it.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issueDst(input logic [3:0] d);
    issue_valid = 1; issue_has_dst = 1; issue_dst = d;
  endtask

  initial begin
    idle();
    rst = 1; issueDst(4'd1);
    #2;
    chk("ready_in_reset", {15'd0, issue_ready}, 16'd0);
    tick(); tick();
    rst = 0; idle(); #1;
    chk("busy_reset", busy_mask, 16'h0000);
    chk("stall_reset", stall_count, 16'd0);
    chk("uflow_reset", {15'd0, wb_underflow}, 16'd0);

    // Producer dst=5 then a dependent consumer.
    issueDst(4'd5); #1;
    chk("ready_dst5", {15'd0, issue_ready}, 16'd1);
    tick(); idle(); #1;
    chk("busy_after_dst5", busy_mask, 16'h0020);
    issue_valid = 1; issue_use_src1 = 1; issue_src1 = 5; #1;
    chk("ready_raw5", {15'd0, issue_ready}, 16'd0);
    tick(); tick(); tick();
    chk("stall_3", stall_count, 16'd3);
    wb_valid = 1; wb_addr = 5; #1;
    chk("ready_wb_cycle", {15'd0, issue_ready}, {15'd0, BYP});
    tick(); wb_valid = 0; #1;
    chk("ready_after_wb", {15'd0, issue_ready}, 16'd1);
    chk("busy_after_wb5", busy_mask, 16'h0000);
    tick(); idle(); #1;
    stExp = BYP ? 16'd3 : 16'd4;
    chk("stall_after_wb", stall_count, stExp);

    // Saturate register 3.
    for (int i = 0; i < 3; i++) begin
      issueDst(4'd3); #1;
      chk("ready_dst3", {15'd0, issue_ready}, 16'd1);
      tick();
    end
    #1;
    chk("ready_dst3_full", {15'd0, issue_ready}, 16'd0);
    chk("busy_dst3", busy_mask, 16'h0008);
    wb_valid = 1; wb_addr = 3; #1;
    chk("ready_full_wb", {15'd0, issue_ready}, 16'd0);
    tick(); wb_valid = 0; #1;
    chk("ready_dst3_after_wb", {15'd0, issue_ready}, 16'd1);
    tick(); idle(); #1;
    stExp = stExp + 16'd1;
    chk("stall_full", stall_count, stExp);
    issueDst(4'd3); #1;
    chk("ready_dst3_refull", {15'd0, issue_ready}, 16'd0);
    idle(); #1;

    // Same-cycle issue and retire on register 7.
    issueDst(4'd7); tick();
    wb_valid = 1; wb_addr = 7; #1;
    chk("ready_dst7_wb7", {15'd0, issue_ready}, 16'd1);
    tick(); idle(); #1;
    chk("busy_net_zero", busy_mask, 16'h0088);

    // Underflow on register 9.
    wb_valid = 1; wb_addr = 9; tick(); idle(); #1;
    chk("uflow_set", {15'd0, wb_underflow}, 16'd1);
    chk("busy_no_9", busy_mask, 16'h0088);

    // Flush with registers 2,4,6 busy.
    issueDst(4'd2); tick();
    issueDst(4'd4); tick();
    issueDst(4'd6); tick();
    idle(); #1;
    chk("busy_before_flush", busy_mask, 16'h00DC);
    flush = 1; issueDst(4'd9); wb_valid = 1; wb_addr = 2; #1;
    chk("ready_flush", {15'd0, issue_ready}, 16'd0);
    tick(); idle(); #1;
    chk("busy_after_flush", busy_mask, 16'h0000);
    chk("uflow_sticky", {15'd0, wb_underflow}, 16'd1);
    chk("stall_flush", stall_count, stExp);

    // Reset in the middle of a stall.
    issueDst(4'd1); tick();
    idle(); issue_valid = 1; issue_use_src1 = 1; issue_src1 = 1;
    tick(); tick();
    chk("stall_pre_rst", stall_count, stExp + 16'd2);
    rst = 1; tick(); rst = 0; idle(); #1;
    chk("stall_rst", stall_count, 16'd0);
    chk("busy_rst", busy_mask, 16'h0000);
    chk("uflow_rst", {15'd0, wb_underflow}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-hazard scoreboard in front of the CPU's 16×32-bit register file read ports. It tracks in-flight writes per architectural register and holds instruction issue while a source operand still has a write outstanding. It also holds issue when the destination's pending counter is saturated. Writeback retirements decrement the counters, and a pipeline flush clears them.

## Interface
Parameters:
- NUM_REGS, 16, number of architectural registers
- ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W
- CNT_W, 2, per-register pending-write counter width; maximum in flight per register = 2**CNT_W−1

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  decode presents an instruction
- issue_ready  out  1  scoreboard accepts it this cycle (combinational)
- issue_use_src1  in  1  instruction reads issue_src1
- issue_src1  in  ADDR_W  first source register, same encoding as register-file readAddr1
- issue_use_src2  in  1  instruction reads issue_src2
- issue_src2  in  ADDR_W  second source register
- issue_has_dst  in  1  instruction writes a register
- issue_dst  in  ADDR_W  destination register
- wb_valid  in  1  a register write retires this cycle; mirrors register-file writeEnable
- wb_addr  in  ADDR_W  retiring register; mirrors writeAddr
- flush  in  1  discard all in-flight writes
- busy_mask  out  NUM_REGS  bit i = 1 when cnt[i] ≠ 0 (registered)
- stall_count  out  16  saturating count of stalled issue cycles
- wb_underflow  out  1  sticky error: a retirement hit a zero counter

## Operation
- State: cnt[0..NUM_REGS−1] (CNT_W bits each), stall_count, wb_underflow.
- Source hazard: hz1 = issue_use_src1 & (cnt[issue_src1] ≠ 0). hz2 is defined the same way for src2.
- Destination full: dfull = issue_has_dst & (cnt[issue_dst] == 2**CNT_W−1).
- issue_ready = ~rst & ~flush & ~hz1 & ~hz2 & ~dfull.
- An issue fires when issue_valid & issue_ready. If issue_has_dst, cnt[issue_dst] increments.
- A retirement occurs when wb_valid & ~flush.
  - If cnt[wb_addr] ≠ 0, cnt[wb_addr] decrements.
  - Otherwise the counter stays 0 and wb_underflow is set.
- If an issue and a retirement target the same register in the same cycle, the net counter change is 0.
- flush: all cnt are cleared on the next edge. Issue and wb_valid in that cycle are ignored. wb_underflow is not cleared.
- stall_count increments when issue_valid & ~issue_ready & ~flush. It saturates at 16'hFFFF.
- busy_mask is registered from the next-state counters, so it matches cnt after each edge.
- The same register used as src1, src2 and dst in one instruction is legal. The hazard check uses only the pre-issue counters.

## Timing
- Reset: while rst is high, issue_ready = 0. On the edge, all cnt = 0, busy_mask = 0, stall_count = 0, wb_underflow = 0.
- Reset asserted mid-operation discards all pending state, with the same result as reset.
- issue_ready has zero latency: it is a combinational function of the current-cycle inputs and the registered counters.
- Counter, busy_mask, stall_count and wb_underflow update 1 cycle after the triggering event.
- Without bypass, a dependent instruction issues at the earliest 1 cycle after its producer's wb_valid cycle. This matches the register file's write-on-edge, read-after behaviour.

## Configuration
- SCOREBOARD_WB_BYPASS_EN defined: the source hazard uses the effective count cnt[src] − (wb_valid & ~flush & wb_addr == src & cnt[src] ≠ 0). A retirement of the last pending write releases a dependent issue in the same cycle. The execute stage must take that operand from wb data.
- Not defined: the hazard uses the raw cnt. A dependent instruction stalls through the wb cycle and issues on the next cycle.
- dfull is unaffected by the macro in both cases.

## Test plan
- Reset, then issue dst=5 → busy_mask = 16'h0020 and cnt[5] = 1. An issue with src1=5 holds issue_ready = 0 and stall_count increments by 1 per cycle.
- Retire wb_addr=5 with src1=5 pending:
  - Without the macro, issue_ready rises on the next cycle.
  - With SCOREBOARD_WB_BYPASS_EN, issue_ready = 1 in the wb cycle.
- Issue dst=3 three times with no wb → cnt[3] = 3. A fourth issue with dst=3 gets issue_ready = 0. After a wb to register 3 it is accepted.
- Issue dst=7 and wb_addr=7 in the same cycle with cnt[7] = 1 → cnt[7] stays 1 and busy_mask bit 7 stays 1.
- wb_valid with wb_addr=9 while cnt[9] = 0 → wb_underflow = 1 next cycle and it stays set after a subsequent flush. cnt[9] stays 0.
- With registers 2, 4 and 6 busy, assert flush together with issue_valid and wb_valid → issue_ready = 0 during flush, and busy_mask = 0 next cycle. Assert rst mid-stall → stall_count = 0.
